// File: rtl/serial_adder4_pkg.sv
// serial_adder4_pkg: shared ALU defines (FSM state encodings and preprocessor op codes)
package serial_adder4_pkg;
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;
   localparam logic [2:0] OP_PASS = 3'b000;
   localparam logic [2:0] OP_NEG  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_INC  = 3'b011;
endpackage

// File: rtl/serial_adder4_fa1.sv
// serial_adder4_fa1: 1-bit full adder shared across all bit slots of the serial adder
module serial_adder4_fa1 (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: rtl/serial_adder4.sv
// serial_adder4: LSB-first bit-serial adder with C/V/N/Z flags, one bit per clock
module serial_adder4 #(
   parameter int W     = 4,
   parameter int CNT_W = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         cin,
   input  logic [W-1:0] AMod,
   input  logic [W-1:0] BMod,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] S,
   output logic         C,
   output logic         V,
   output logic         N,
   output logic         Z
);
   import serial_adder4_pkg::*;

   state_t           r_state;
   logic [W-1:0]     r_a_sh;
   logic [W-1:0]     r_b_sh;
   logic [W-1:0]     r_s_sh;
   logic             r_carry;
   logic [CNT_W-1:0] r_cnt;
   logic             w_sum;
   logic             w_co;
   logic [W-1:0]     w_s_next;

   serial_adder4_fa1 u_fa (
      .a  (r_a_sh[0]),
      .b  (r_b_sh[0]),
      .ci (r_carry),
      .s  (w_sum),
      .co (w_co)
   );

   // sum register as it will look after this bit is shifted in
   assign w_s_next = {w_sum, r_s_sh[W-1:1]};

   // control FSM plus datapath; flags latch only when the last bit is processed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_a_sh  <= '0;
         r_b_sh  <= '0;
         r_s_sh  <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         S       <= '0;
         C       <= 1'b0;
         V       <= 1'b0;
         N       <= 1'b0;
         Z       <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_a_sh  <= AMod;
                  r_b_sh  <= BMod;
                  r_carry <= cin;
                  r_cnt   <= '0;
                  busy    <= 1'b1;
                  r_state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               r_s_sh  <= w_s_next;
               r_a_sh  <= r_a_sh >> 1;
               r_b_sh  <= r_b_sh >> 1;
               r_carry <= w_co;
               r_cnt   <= r_cnt + 1'b1;
               if (r_cnt == CNT_W'(W - 1)) begin
                  S       <= w_s_next;
                  C       <= w_co;
                  V       <= r_carry ^ w_co;
                  N       <= w_sum;
                  Z       <= ~|w_s_next;
                  done    <= 1'b1;
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end
endmodule
